// File: rtl/mem_crypt_bridge.sv
// ---------------------------------------------------------------------------
// mem_crypt_bridge
//
// Sits between a core and main memory and handles one transaction at a time.
// Writes to the encrypted region (address MSB clear) have their data XORed
// with a keystream before they are forwarded. Read data coming back from that
// region is XORed with the same keystream. The keystream is the key XORed with
// the low 12 address bits. The key, the enable and the keystream are captured
// when the request is accepted, so changes made later have no effect on a
// transaction that is already in flight.
//
// Ports
//   clock, reset          sole clock; asynchronous active-high reset
//   up_msg_in/address/data    core request   (NONE=0, READ=1, WRITE=2)
//   up_msg_out/address/data   core response  (NONE=0, DATA=1, ACK=2, ERR=7)
//   dn_msg_out/address/data   request to the memory port
//   dn_msg_in/address/data    response from the memory port
//   key, enc_enable       cipher key and crypto enable
//   busy                  high whenever the FSM is not in IDLE
//   rd_dec_count          saturating count of decrypted READ responses
//   wr_enc_count          saturating count of encrypted WRITE issues
// ---------------------------------------------------------------------------
module mem_crypt_bridge #(
    parameter int ADDRESS_BITS = 12,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2:0]              up_msg_in,
    input  logic [ADDRESS_BITS:0]   up_address_in,
    input  logic [31:0]             up_data_in,
    output logic [2:0]              up_msg_out,
    output logic [ADDRESS_BITS:0]   up_address_out,
    output logic [31:0]             up_data_out,
    output logic [2:0]              dn_msg_out,
    output logic [ADDRESS_BITS:0]   dn_address_out,
    output logic [31:0]             dn_data_out,
    input  logic [2:0]              dn_msg_in,
    input  logic [ADDRESS_BITS:0]   dn_address_in,
    input  logic [31:0]             dn_data_in,
    input  logic [31:0]             key,
    input  logic                    enc_enable,
    output logic                    busy,
    output logic [15:0]             rd_dec_count,
    output logic [15:0]             wr_enc_count
);

    localparam logic [2:0] REQ_NONE  = 3'd0;
    localparam logic [2:0] REQ_READ  = 3'd1;
    localparam logic [2:0] REQ_WRITE = 3'd2;
    localparam logic [2:0] RSP_NONE  = 3'd0;
    localparam logic [2:0] RSP_DATA  = 3'd1;
    localparam logic [2:0] RSP_ACK   = 3'd2;
    localparam logic [2:0] RSP_ERR   = 3'd7;

    // The last WAIT cycle: when the counter would step onto TIMEOUT, give up.
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Keystream: key XOR the low 12 address bits, zero-extended to 32 bits.
    function automatic logic [31:0] keystream_f(input logic [31:0] k,
                                                input logic [ADDRESS_BITS-1:0] a);
        return k ^ (32'(a) & 32'h0000_0FFF);
    endfunction

    // Saturating increment for the 16-bit event counters.
    function automatic logic [15:0] sat_inc_f(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : (c + 16'd1);
    endfunction

    state_t                  state_q,   state_d;
    logic [2:0]              req_q,     req_d;
    logic [ADDRESS_BITS:0]   addr_q,    addr_d;
    logic [31:0]             ks_q,      ks_d;
    logic                    crypt_q,   crypt_d;
    logic [7:0]              tmo_q,     tmo_d;
    logic [2:0]              up_msg_q,  up_msg_d;
    logic [ADDRESS_BITS:0]   up_addr_q, up_addr_d;
    logic [31:0]             up_data_q, up_data_d;
    logic [2:0]              dn_msg_q,  dn_msg_d;
    logic [ADDRESS_BITS:0]   dn_addr_q, dn_addr_d;
    logic [31:0]             dn_data_q, dn_data_d;
    logic                    busy_q,    busy_d;
    logic [15:0]             rd_cnt_q,  rd_cnt_d;
    logic [15:0]             wr_cnt_q,  wr_cnt_d;

    logic                    new_req_s;
    logic                    new_crypt_s;
    logic [31:0]             new_ks_s;
    logic                    match_s;

    // Request decode and the crypt decision for a request arriving in IDLE.
    always_comb begin
        new_req_s   = (up_msg_in == REQ_READ) || (up_msg_in == REQ_WRITE);
        new_crypt_s = enc_enable && !up_address_in[ADDRESS_BITS];
        new_ks_s    = keystream_f(key, up_address_in[ADDRESS_BITS-1:0]);
        match_s     = (dn_msg_in != RSP_NONE) && (dn_address_in == addr_q);
    end

    // Next-state and output logic. Outputs are computed here one cycle early
    // so that each registered output is valid for the whole state it belongs to.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        ks_d      = ks_q;
        crypt_d   = crypt_q;
        tmo_d     = tmo_q;
        up_msg_d  = RSP_NONE;
        up_addr_d = up_addr_q;
        up_data_d = up_data_q;
        dn_msg_d  = REQ_NONE;
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (new_req_s) begin
                    state_d   = ST_ISSUE;
                    req_d     = up_msg_in;
                    addr_d    = up_address_in;
                    ks_d      = new_ks_s;
                    crypt_d   = new_crypt_s;
                    dn_msg_d  = up_msg_in;
                    dn_addr_d = up_address_in;
                    // Only write payloads are ciphered on the way down.
                    if ((up_msg_in == REQ_WRITE) && new_crypt_s) begin
                        dn_data_d = up_data_in ^ new_ks_s;
                        wr_cnt_d  = sat_inc_f(wr_cnt_q);
                    end else begin
                        dn_data_d = up_data_in;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                tmo_d   = 8'd0;
            end
            ST_WAIT: begin
                // A matching response wins over a timeout in the same cycle.
                if (match_s) begin
                    state_d   = ST_RESP;
                    up_addr_d = addr_q;
                    if (req_q == REQ_WRITE) begin
                        up_msg_d  = RSP_ACK;
                        up_data_d = dn_data_in;
                    end else begin
                        up_msg_d  = RSP_DATA;
                        if (crypt_q) begin
                            up_data_d = dn_data_in ^ ks_q;
                            rd_cnt_d  = sat_inc_f(rd_cnt_q);
                        end else begin
                            up_data_d = dn_data_in;
                        end
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    state_d   = ST_RESP;
                    tmo_d     = tmo_q + 8'd1;
                    up_msg_d  = RSP_ERR;
                    up_addr_d = addr_q;
                    up_data_d = 32'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 3'd0;
            addr_q    <= '0;
            ks_q      <= 32'd0;
            crypt_q   <= 1'b0;
            tmo_q     <= 8'd0;
            up_msg_q  <= 3'd0;
            up_addr_q <= '0;
            up_data_q <= 32'd0;
            dn_msg_q  <= 3'd0;
            dn_addr_q <= '0;
            dn_data_q <= 32'd0;
            busy_q    <= 1'b0;
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            ks_q      <= ks_d;
            crypt_q   <= crypt_d;
            tmo_q     <= tmo_d;
            up_msg_q  <= up_msg_d;
            up_addr_q <= up_addr_d;
            up_data_q <= up_data_d;
            dn_msg_q  <= dn_msg_d;
            dn_addr_q <= dn_addr_d;
            dn_data_q <= dn_data_d;
            busy_q    <= busy_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign up_msg_out     = up_msg_q;
    assign up_address_out = up_addr_q;
    assign up_data_out    = up_data_q;
    assign dn_msg_out     = dn_msg_q;
    assign dn_address_out = dn_addr_q;
    assign dn_data_out    = dn_data_q;
    assign busy           = busy_q;
    assign rd_dec_count   = rd_cnt_q;
    assign wr_enc_count   = wr_cnt_q;

endmodule

// File: tb/tb_mem_crypt_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_crypt_bridge
//
// Self-checking bench for mem_crypt_bridge. Each transaction pushes its
// expected core response onto a scoreboard queue. A monitor pops the queue
// whenever up_msg_out is non-NONE and compares the message, address, data
// and latency. Memory responses are driven by the transaction task.
// ---------------------------------------------------------------------------
module tb_mem_crypt_bridge;

    localparam int AB  = 12;
    localparam int TMO = 16;

    logic          clock;
    logic          reset;
    logic [2:0]    up_msg_in;
    logic [AB:0]   up_address_in;
    logic [31:0]   up_data_in;
    logic [2:0]    up_msg_out;
    logic [AB:0]   up_address_out;
    logic [31:0]   up_data_out;
    logic [2:0]    dn_msg_out;
    logic [AB:0]   dn_address_out;
    logic [31:0]   dn_data_out;
    logic [2:0]    dn_msg_in;
    logic [AB:0]   dn_address_in;
    logic [31:0]   dn_data_in;
    logic [31:0]   key;
    logic          enc_enable;
    logic          busy;
    logic [15:0]   rd_dec_count;
    logic [15:0]   wr_enc_count;

    mem_crypt_bridge #(.ADDRESS_BITS(AB), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .up_msg_in(up_msg_in), .up_address_in(up_address_in), .up_data_in(up_data_in),
        .up_msg_out(up_msg_out), .up_address_out(up_address_out), .up_data_out(up_data_out),
        .dn_msg_out(dn_msg_out), .dn_address_out(dn_address_out), .dn_data_out(dn_data_out),
        .dn_msg_in(dn_msg_in), .dn_address_in(dn_address_in), .dn_data_in(dn_data_in),
        .key(key), .enc_enable(enc_enable), .busy(busy),
        .rd_dec_count(rd_dec_count), .wr_enc_count(wr_enc_count)
    );

    typedef struct {
        logic [2:0]  msg;
        logic [AB:0] addr;
        logic [31:0] data;
        logic        chk_data;
        int          lat;
        int          req_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_resp   = 0;
    int   cyc      = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Response monitor: every non-NONE up_msg_out must match the scoreboard head.
    always @(posedge clock) begin
        #1;
        if (up_msg_out !== 3'd0) begin
            n_resp++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rsp", 32'(up_msg_out), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_msg", 32'(up_msg_out), 32'(e.msg));
                check_eq("rsp_addr", 32'(up_address_out), 32'(e.addr));
                if (e.chk_data) check_eq("rsp_data", up_data_out, e.data);
                check_eq("rsp_latency", 32'(cyc - e.req_cyc), 32'(e.lat));
            end
        end
    end

    // One full transaction: request, downstream check, memory reply, response wait.
    task automatic run_txn(input logic [2:0] msg, input logic [AB:0] addr,
                           input logic [31:0] wdata, input int delay,
                           input logic [AB:0] rsp_addr, input logic [31:0] rdata,
                           input logic [2:0] exp_msg, input logic [31:0] exp_dn,
                           input logic [31:0] exp_up, input logic chk_data,
                           input int exp_lat, input logic key_swap);
        int   start;
        int   budget;
        exp_t e;
        start = n_resp;
        @(negedge clock);
        up_msg_in = msg; up_address_in = addr; up_data_in = wdata;
        @(posedge clock); #1;
        up_msg_in = 3'd0; up_address_in = '0; up_data_in = 32'd0;
        e.msg = exp_msg; e.addr = addr; e.data = exp_up; e.chk_data = chk_data;
        e.lat = exp_lat; e.req_cyc = cyc;
        sb_q.push_back(e);
        check_eq("dn_msg", 32'(dn_msg_out), 32'(msg));
        check_eq("dn_addr", 32'(dn_address_out), 32'(addr));
        check_eq("dn_data", dn_data_out, exp_dn);
        check_eq("busy_issue", 32'(busy), 32'd1);
        @(posedge clock); #1;
        check_eq("dn_msg_one_cycle", 32'(dn_msg_out), 32'd0);
        if (key_swap) key = 32'd0;
        repeat (delay - 1) @(negedge clock);
        dn_msg_in     = (msg == 3'd2) ? 3'd2 : 3'd1;
        dn_address_in = rsp_addr;
        dn_data_in    = rdata;
        @(negedge clock);
        dn_msg_in = 3'd0; dn_address_in = '0; dn_data_in = 32'd0;
        budget = 0;
        while (n_resp == start && budget < 40) begin
            @(posedge clock); #2;
            budget++;
        end
        if (n_resp == start) check_eq("rsp_wait_bound", 32'(n_resp - start), 32'd1);
        @(posedge clock); #1;
        check_eq("rsp_one_cycle", 32'(up_msg_out), 32'd0);
        check_eq("busy_after", 32'(busy), 32'd0);
        if (key_swap) key = 32'hDEADBEEF;
    endtask

    initial begin
        reset = 1'b1;
        up_msg_in = 3'd0; up_address_in = '0; up_data_in = 32'd0;
        dn_msg_in = 3'd0; dn_address_in = '0; dn_data_in = 32'd0;
        key = 32'd0; enc_enable = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_up_msg", 32'(up_msg_out), 32'd0);
        check_eq("rst_dn_msg", 32'(dn_msg_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_cnt", 32'(rd_dec_count), 32'd0);
        check_eq("rst_wr_cnt", 32'(wr_enc_count), 32'd0);
        check_eq("rst_dn_addr", 32'(dn_address_out), 32'd0);
        check_eq("rst_up_data", up_data_out, 32'd0);
        // Release right after an edge so the next request lands on the first edge.
        reset = 1'b0;
        key = 32'hDEADBEEF; enc_enable = 1'b1;

        // Encrypted read, memory replies after 3 cycles.
        run_txn(3'd1, 13'h010, 32'd0, 3, 13'h010, 32'h12345678,
                3'd1, 32'd0, 32'hCC99E887, 1'b1, 3, 1'b0);
        check_eq("rd_cnt_1", 32'(rd_dec_count), 32'd1);

        // Same read, key cleared during WAIT: captured keystream still applies.
        run_txn(3'd1, 13'h010, 32'd0, 3, 13'h010, 32'h12345678,
                3'd1, 32'd0, 32'hCC99E887, 1'b1, 3, 1'b1);
        check_eq("rd_cnt_2", 32'(rd_dec_count), 32'd2);

        // Encrypted write with the earliest possible memory reply.
        run_txn(3'd2, 13'h004, 32'd0, 2, 13'h004, 32'd0,
                3'd2, 32'hDEADBEEB, 32'd0, 1'b0, 2, 1'b0);
        check_eq("wr_cnt_1", 32'(wr_enc_count), 32'd1);

        // Same write in the plaintext region: no cipher, no count.
        run_txn(3'd2, 13'h1004, 32'd0, 2, 13'h1004, 32'd0,
                3'd2, 32'd0, 32'd0, 1'b0, 2, 1'b0);
        check_eq("wr_cnt_plain", 32'(wr_enc_count), 32'd1);

        // Plaintext read with a non-zero payload through the write path of dn_data.
        run_txn(3'd1, 13'h1010, 32'd0, 4, 13'h1010, 32'hA5A5_0F0F,
                3'd1, 32'd0, 32'hA5A5_0F0F, 1'b1, 4, 1'b0);
        check_eq("rd_cnt_plain", 32'(rd_dec_count), 32'd2);

        // Crypto disabled: read data passes through unchanged.
        enc_enable = 1'b0;
        run_txn(3'd1, 13'h010, 32'd0, 3, 13'h010, 32'h12345678,
                3'd1, 32'd0, 32'h12345678, 1'b1, 3, 1'b0);
        check_eq("rd_cnt_disabled", 32'(rd_dec_count), 32'd2);
        enc_enable = 1'b1;

        // Only a wrong-address reply: ERR with zero data after TMO WAIT cycles.
        run_txn(3'd1, 13'h010, 32'd0, 3, 13'h011, 32'h12345678,
                3'd7, 32'd0, 32'd0, 1'b1, TMO + 1, 1'b0);
        check_eq("rd_cnt_err", 32'(rd_dec_count), 32'd2);

        // Match arriving in the cycle the counter reaches TMO: match wins.
        run_txn(3'd1, 13'h020, 32'd0, TMO + 1, 13'h020, 32'h0000_0000,
                3'd1, 32'd0, 32'hDEADBECF, 1'b1, TMO + 1, 1'b0);
        check_eq("rd_cnt_boundary", 32'(rd_dec_count), 32'd3);

        // Reset pulsed mid-WAIT; the late memory reply must produce nothing.
        @(negedge clock);
        up_msg_in = 3'd1; up_address_in = 13'h010;
        @(posedge clock); #1;
        up_msg_in = 3'd0; up_address_in = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("busy_wait", 32'(busy), 32'd1);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        dn_msg_in = 3'd1; dn_address_in = 13'h010; dn_data_in = 32'h12345678;
        @(negedge clock);
        dn_msg_in = 3'd0; dn_address_in = '0; dn_data_in = 32'd0;
        repeat (4) @(posedge clock);
        #1;
        check_eq("abort_up_msg", 32'(up_msg_out), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rd_cnt", 32'(rd_dec_count), 32'd0);
        check_eq("abort_wr_cnt", 32'(wr_enc_count), 32'd0);
        check_eq("abort_sb_empty", 32'(sb_q.size()), 32'd0);

        // Normal read after the aborted one.
        run_txn(3'd1, 13'h010, 32'd0, 2, 13'h010, 32'h12345678,
                3'd1, 32'd0, 32'hCC99E887, 1'b1, 2, 1'b0);
        check_eq("rd_cnt_after_abort", 32'(rd_dec_count), 32'd1);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
